regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-issue integer register file.
- DEPTH registers of DATA_W bits, with NUM_RD combinational read ports and NUM_WR synchronous write ports.
- Register 0 is hardwired to zero. Same-cycle write-to-read bypass is optional.
- An integrated scoreboard tracks registers with an in-flight producer so decode can stall on RAW hazards.
- Sits between id (reads, reservations) and ex/wb (writes, releases) in a dual-issue-capable core.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of architectural registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), register address width.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports. Higher index has priority on an address collision.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr_i  in  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data_o  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy_o  out  NUM_RD  per read port: the addressed register has a pending producer.
- wr_en_i  in  NUM_WR  per-port write enable.
- wr_addr_i  in  NUM_WR*ADDR_W  packed write addresses.
- wr_data_i  in  NUM_WR*DATA_W  packed write data.
- wr_rel_i  in  NUM_WR  per port: this write also releases the scoreboard entry. Only meaningful when wr_en_i is high.
- rsv_en_i  in  1  reserve request from id.
- rsv_addr_i  in  ADDR_W  register being reserved.
- busy_vec_o  out  DEPTH  raw scoreboard bits, for debug and stall logic.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0 and all busy bits clear.
  - rd_data_o = 0, rd_busy_o = 0, busy_vec_o = 0 for as long as rst_n is low.
- Write:
  - On a rising edge, each port w with wr_en_i[w]=1 and wr_addr_i[w]!=0 stores wr_data_i[w].
  - Writes to address 0 are discarded.
  - If several enabled ports target the same address, the highest-index port's data is stored.
- Read:
  - rd_data_o[k] is a purely combinational function of rd_addr_i[k] and the current state, so visible data latency is 0 cycles.
  - Address 0 always returns 0.
- Bypass (REGFILE_BYPASS_EN defined):
  - If any enabled write port targets rd_addr_i[k] (non-zero) in the same cycle, rd_data_o[k] returns that port's wr_data_i.
  - The same highest-index priority applies.
- Scoreboard (one busy bit per register; bit 0 is constant 0):
  - Set: rsv_en_i=1 and rsv_addr_i!=0 sets busy[rsv_addr_i] at the edge.
  - Clear: wr_en_i[w] & wr_rel_i[w] clears busy[wr_addr_i[w]] at the edge.
  - Same-edge set and clear of the same address: set wins, because a new producer supersedes the retiring one.
  - A release of a register that is not busy is a no-op.
  - Reserve of x0 is ignored.
- rd_busy_o[k] = busy[rd_addr_i[k]], except:
  - When REGFILE_BYPASS_EN is defined and a releasing write to that address is present in the same cycle, rd_busy_o[k] = 0, because the data is bypassed.
  - Address 0 is never busy.
- Address out of range (DEPTH not reaching 2^ADDR_W cannot occur, since DEPTH is a power of two): no special handling.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - Write-through forwarding on rd_data_o.
  - rd_busy_o is masked by same-cycle releasing writes, as above.
- Not defined:
  - Reads return stored contents only; a write becomes visible the cycle after its edge.
  - rd_busy_o reflects the registered busy bits only.
  - Saves NUM_RD x NUM_WR comparators and muxes.

Decomposition:
- Shared package (define.v):
  - RstEnable and ZeroWord, reused.
  - New constants REGFILE_DATA_W, REGFILE_DEPTH, REGFILE_NUM_RD, REGFILE_NUM_WR as defaults for the core top.
- One natural sub-module: regfile_scoreboard.
  - Contents: the busy-bit array with set/clear/priority logic and per-port lookup.
  - Parameters: DEPTH, ADDR_W, NUM_RD, NUM_WR.
  - Storage, write-priority and bypass muxing remain in regfile_mp.

Test Plan:
1. Reset then read: hold rst_n=0 with arbitrary addresses -> all rd_data_o=0 and busy_vec_o=0. Release reset, read x5 -> 0.
2. Write/read and x0: wr0 writes 0xDEADBEEF to x3, and wr1 writes 0x1234 to x0 on the same edge. Next cycle: x3 reads 0xDEADBEEF, x0 reads 0.
3. Write collision: wr0 writes 0xAAAA0000 and wr1 writes 0x5555FFFF, both to x7, on one edge -> x7 reads 0x5555FFFF.
4. Bypass: with the macro defined, read x9 while wr1 writes 0xCAFE to x9 -> rd_data_o=0xCAFE in the same cycle. Without the macro, the old value is returned that cycle and 0xCAFE the next.
5. Scoreboard: reserve x4 -> busy_vec_o[4]=1 and rd_busy_o=1 for x4. Then, on one edge, reserve x4 while wr0 releases x4 -> bit stays 1. A later release alone -> bit clears to 0.
6. Reset mid-operation: drop rst_n between clock edges while x4 is busy and x3=0xDEADBEEF -> outputs go to 0 immediately (asynchronously) and remain 0 after reset is released.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file and its scoreboard.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_mp_pkg;

   // Active level of rst_n and the all-zeros data word, shared with the core.
   localparam logic        RstEnable = 1'b0;
   localparam logic [31:0] ZeroWord  = 32'h0000_0000;

   // Default geometry of the core's register file.
   localparam int REGFILE_DATA_W = 32;
   localparam int REGFILE_DEPTH  = 32;
   localparam int REGFILE_NUM_RD = 2;
   localparam int REGFILE_NUM_WR = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an in-flight producer.
// Latency: set/clear visible on busy_vec_o one cycle after the edge; lookups combinational.
// Backpressure: none; decode stalls itself on rd_busy_o.
// Ports: clk/rst_n; rd_addr_i -> rd_busy_o lookup; wr_en_i/wr_addr_i/wr_rel_i release;
//        rsv_en_i/rsv_addr_i reserve; busy_vec_o raw bits.
// Config: REGFILE_BYPASS_EN masks rd_busy_o with same-cycle releasing writes.
module regfile_scoreboard
   import regfile_mp_pkg::*;
#(
   parameter int DEPTH  = REGFILE_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NUM_RD = REGFILE_NUM_RD,
   parameter int NUM_WR = REGFILE_NUM_WR
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_WR-1:0]        wr_rel_i,
   input  logic                     rsv_en_i,
   input  logic [ADDR_W-1:0]        rsv_addr_i,
   output logic [DEPTH-1:0]         busy_vec_o
);

   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [ADDR_W-1:0] rd_addr [NUM_RD];
   logic [ADDR_W-1:0] wr_addr [NUM_WR];

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
      assign rd_addr[k] = rd_addr_i[k*ADDR_W +: ADDR_W];
   end
   for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_unpack
      assign wr_addr[w] = wr_addr_i[w*ADDR_W +: ADDR_W];
   end

   // Clears are applied first so a same-edge reserve overrides them:
   // the new producer supersedes the one retiring.
   always_comb begin
      busy_d = busy_q;
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_en_i[w] && wr_rel_i[w]) busy_d[wr_addr[w]] = 1'b0;
      end
      if (rsv_en_i) busy_d[rsv_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   always_comb begin
      rd_busy_o = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_busy_o[k] = busy_q[rd_addr[k]] && (rd_addr[k] != '0);
`ifdef REGFILE_BYPASS_EN
         // The releasing write's data is forwarded, so the reader need not stall.
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && wr_rel_i[w] && (wr_addr[w] == rd_addr[k])) rd_busy_o[k] = 1'b0;
         end
`endif
      end
   end

   assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file (x0 hardwired to zero) with integrated RAW scoreboard.
// Latency: reads combinational (0 cycles); writes visible the cycle after the edge, or same cycle with bypass.
// Backpressure: none; consumers stall on rd_busy_o / busy_vec_o.
// Ports: rd_addr_i -> rd_data_o/rd_busy_o (per read port, packed); wr_en_i/wr_addr_i/wr_data_i/wr_rel_i
//        (per write port, higher index wins on collision); rsv_en_i/rsv_addr_i reserve; busy_vec_o.
// Config: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = REGFILE_DATA_W,
   parameter int DEPTH  = REGFILE_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NUM_RD = REGFILE_NUM_RD,
   parameter int NUM_WR = REGFILE_NUM_WR
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
   input  logic [NUM_WR-1:0]        wr_rel_i,
   input  logic                     rsv_en_i,
   input  logic [ADDR_W-1:0]        rsv_addr_i,
   output logic [DEPTH-1:0]         busy_vec_o
);

   logic [DATA_W-1:0] mem_q   [DEPTH];
   logic [ADDR_W-1:0] rd_addr [NUM_RD];
   logic [DATA_W-1:0] rd_dat  [NUM_RD];
   logic [ADDR_W-1:0] wr_addr [NUM_WR];
   logic [DATA_W-1:0] wr_dat  [NUM_WR];

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign rd_addr[k]                    = rd_addr_i[k*ADDR_W +: ADDR_W];
      assign rd_data_o[k*DATA_W +: DATA_W] = rd_dat[k];
   end
   for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
      assign wr_addr[w] = wr_addr_i[w*ADDR_W +: ADDR_W];
      assign wr_dat[w]  = wr_data_i[w*DATA_W +: DATA_W];
   end

   // Ports are scanned in ascending order, so the last (highest-index)
   // nonblocking write to a shared address is the one that lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr[w] != '0)) mem_q[wr_addr[w]] <= wr_dat[w];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         rd_dat[k] = mem_q[rd_addr[k]];
`ifdef REGFILE_BYPASS_EN
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr[w] == rd_addr[k])) rd_dat[k] = wr_dat[w];
         end
`endif
         // x0 reads zero; reset also forces zero so bypassed write data cannot leak out.
         if ((rd_addr[k] == '0) || (rst_n == RstEnable)) rd_dat[k] = '0;
      end
   end

   regfile_scoreboard #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_addr_i  (rd_addr_i),
      .rd_busy_o  (rd_busy_o),
      .wr_en_i    (wr_en_i),
      .wr_addr_i  (wr_addr_i),
      .wr_rel_i   (wr_rel_i),
      .rsv_en_i   (rsv_en_i),
      .rsv_addr_i (rsv_addr_i),
      .busy_vec_o (busy_vec_o)
   );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   logic                clk;
   logic                rst_n;
   logic [2*ADDR_W-1:0] rd_addr_i;
   logic [2*DATA_W-1:0] rd_data_o;
   logic [1:0]          rd_busy_o;
   logic [1:0]          wr_en_i;
   logic [2*ADDR_W-1:0] wr_addr_i;
   logic [2*DATA_W-1:0] wr_data_i;
   logic [1:0]          wr_rel_i;
   logic                rsv_en_i;
   logic [ADDR_W-1:0]   rsv_addr_i;
   logic [DEPTH-1:0]    busy_vec_o;

   int n_chk  = 0;
   int n_fail = 0;

   regfile_mp dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_addr_i  (rd_addr_i),
      .rd_data_o  (rd_data_o),
      .rd_busy_o  (rd_busy_o),
      .wr_en_i    (wr_en_i),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .wr_rel_i   (wr_rel_i),
      .rsv_en_i   (rsv_en_i),
      .rsv_addr_i (rsv_addr_i),
      .busy_vec_o (busy_vec_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en_i  = '0;
      wr_rel_i = '0;
      rsv_en_i = 1'b0;
   endtask

   task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
      rd_addr_i = {a1, a0};
   endtask

   task automatic set_wr(input logic [1:0] en, input logic [1:0] rel,
                         input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
      wr_en_i   = en;
      wr_rel_i  = rel;
      wr_addr_i = {a1, a0};
      wr_data_i = {d1, d0};
   endtask

   initial begin
      rst_n      = 1'b0;
      rsv_addr_i = '0;
      idle();
      set_rd(5'd3, 5'd5);
      // Activity during reset must not disturb the cleared outputs.
      set_wr(2'b11, 2'b00, 5'd3, 32'h1111_2222, 5'd5, 32'h3333_4444);
      rsv_en_i   = 1'b1;
      rsv_addr_i = 5'd2;
      tick();
      tick();
      check("rst_rd0",     rd_data_o[31:0],  32'h0);
      check("rst_rd1",     rd_data_o[63:32], 32'h0);
      check("rst_busyvec", busy_vec_o,       32'h0);
      check("rst_rdbusy",  rd_busy_o,        2'b00);
      idle();
      #2 rst_n = 1'b1;
      tick();
      check("post_rst_x5", rd_data_o[63:32], 32'h0);

      // Write x3, and an attempted write of x0 on the same edge.
      set_wr(2'b11, 2'b00, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'h0000_1234);
      tick();
      idle();
      set_rd(5'd3, 5'd0);
      #1;
      check("wr_x3", rd_data_o[31:0],  32'hDEAD_BEEF);
      check("wr_x0", rd_data_o[63:32], 32'h0);

      // Collision on x7: port 1 wins.
      set_wr(2'b11, 2'b00, 5'd7, 32'hAAAA_0000, 5'd7, 32'h5555_FFFF);
      tick();
      idle();
      set_rd(5'd7, 5'd7);
      #1;
      check("coll_x7_p0", rd_data_o[31:0],  32'h5555_FFFF);
      check("coll_x7_p1", rd_data_o[63:32], 32'h5555_FFFF);

      // Seed x9 with an old value, then overwrite it while reading.
      set_wr(2'b01, 2'b00, 5'd9, 32'h0000_1111, 5'd0, 32'h0);
      tick();
      set_wr(2'b10, 2'b00, 5'd0, 32'h0, 5'd9, 32'h0000_CAFE);
      set_rd(5'd9, 5'd3);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_x9_same", rd_data_o[31:0], 32'h0000_CAFE);
`else
      check("byp_x9_same", rd_data_o[31:0], 32'h0000_1111);
`endif
      check("byp_x3_other", rd_data_o[63:32], 32'hDEAD_BEEF);
      tick();
      idle();
      #1;
      check("byp_x9_next", rd_data_o[31:0], 32'h0000_CAFE);

      // Same-cycle collision on x10 while reading it.
      set_wr(2'b11, 2'b00, 5'd10, 32'h0A0A_0A0A, 5'd10, 32'h0B0B_0B0B);
      set_rd(5'd10, 5'd10);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_coll_x10", rd_data_o[31:0], 32'h0B0B_0B0B);
`else
      check("byp_coll_x10", rd_data_o[31:0], 32'h0);
`endif
      tick();
      idle();
      #1;
      check("coll_x10_next", rd_data_o[63:32], 32'h0B0B_0B0B);

      // Scoreboard: reserve x4.
      rsv_en_i   = 1'b1;
      rsv_addr_i = 5'd4;
      tick();
      idle();
      set_rd(5'd4, 5'd0);
      #1;
      check("sb_vec_set",  busy_vec_o,   32'h0000_0010);
      check("sb_rd4_busy", rd_busy_o[0], 1'b1);
      check("sb_rd0_idle", rd_busy_o[1], 1'b0);

      // Reserve and release x4 on one edge: reserve wins.
      rsv_en_i   = 1'b1;
      rsv_addr_i = 5'd4;
      set_wr(2'b01, 2'b01, 5'd4, 32'h0000_0044, 5'd0, 32'h0);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("sb_rel_mask", rd_busy_o[0], 1'b0);
`else
      check("sb_rel_mask", rd_busy_o[0], 1'b1);
`endif
      tick();
      idle();
      #1;
      check("sb_set_wins", busy_vec_o, 32'h0000_0010);

      // Release x4 alone, plus a no-op release of idle x6 on port 1.
      set_wr(2'b11, 2'b11, 5'd4, 32'h0000_0045, 5'd6, 32'h0000_0066);
      tick();
      idle();
      #1;
      check("sb_release", busy_vec_o,   32'h0);
      check("sb_rd4_free", rd_busy_o[0], 1'b0);

      // Reserve of x0 is ignored.
      rsv_en_i   = 1'b1;
      rsv_addr_i = 5'd0;
      tick();
      idle();
      #1;
      check("sb_rsv_x0", busy_vec_o, 32'h0);

      // Asynchronous reset mid-cycle with x4 busy and x3 holding data.
      rsv_en_i   = 1'b1;
      rsv_addr_i = 5'd4;
      tick();
      idle();
      set_rd(5'd3, 5'd4);
      #1;
      check("pre_arst_x3",  rd_data_o[31:0], 32'hDEAD_BEEF);
      check("pre_arst_vec", busy_vec_o,      32'h0000_0010);
      #1 rst_n = 1'b0;
      #1;
      check("arst_x3",     rd_data_o[31:0], 32'h0);
      check("arst_vec",    busy_vec_o,      32'h0);
      check("arst_rdbusy", rd_busy_o,       2'b00);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_arst_x3",  rd_data_o[31:0],  32'h0);
      check("post_arst_x4",  rd_data_o[63:32], 32'h0);
      check("post_arst_vec", busy_vec_o,       32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
